// File: rtl/seq_tx_if.sv
// Load handshake and serial output bundle for the seq_tx frame transmitter.
// Handshake: a word transfers on a rising clk edge where load_valid=1 and
// load_ready=1. load_valid while load_ready=0 is dropped and never queued.
// load_data is only sampled on the transfer edge.
interface seq_tx_if #(
    parameter int PAYLOAD_W = 16
);
    logic                 load_valid;
    logic [PAYLOAD_W-1:0] load_data;
    logic                 load_ready;
    logic                 tx_out;
    logic                 tx_active;
    logic                 tx_stuff;
    logic                 frame_done;

    // Source of payload words, observer of the serial line.
    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  tx_out,
        input  tx_active,
        input  tx_stuff,
        input  frame_done
    );

    // The transmitter itself.
    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output tx_out,
        output tx_active,
        output tx_stuff,
        output frame_done
    );
endinterface

// File: rtl/seq_tx.sv
// Serial frame transmitter: 5-bit sync preamble 1,0,1,1,0, payload LSB first
// with a stuffed 1 after every "1011" in the data/stuff stream, then two guard
// zeros. All outputs are registered; the state register describes the bit
// currently on tx_out.
module seq_tx #(
    parameter int PAYLOAD_W = 16
) (
    input logic   clk,
    input logic   rst_n,
    seq_tx_if.slave bus
);
    localparam int CNT_W = $clog2(PAYLOAD_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_W);
    // Preamble bit i is emitted i-th: 1,0,1,1,0.
    localparam logic [4:0] PREAMBLE = 5'b01101;

    typedef enum logic [2:0] {IDLE, PRE, DATA, STUFF, GUARD} state_t;

    state_t               state, state_nx;
    logic [PAYLOAD_W-1:0] shreg, shreg_nx;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nx;
    logic [2:0]           pre_cnt, pre_cnt_nx;
    logic [2:0]           trk, trk_nx;
    logic [2:0]           trk_base;
    logic                 guard_cnt, guard_cnt_nx;
    logic                 emit_data;
    logic                 tx_out_q, tx_out_nx;
    logic                 tx_stuff_q, tx_stuff_nx;
    logic                 frame_done_q, frame_done_nx;
    logic                 tx_active_q;
    logic                 load_ready_q;

    // Progress through the pattern 1,0,1,1: value is the matched prefix length.
    function automatic logic [2:0] next_trk(input logic [2:0] t, input logic b);
        case (t)
            3'd0:    next_trk = b ? 3'd1 : 3'd0;
            3'd1:    next_trk = b ? 3'd1 : 3'd2;
            3'd2:    next_trk = b ? 3'd3 : 3'd0;
            3'd3:    next_trk = b ? 3'd4 : 3'd2;
            default: next_trk = b ? 3'd1 : 3'd0;
        endcase
    endfunction

    assign bus.load_ready = load_ready_q;
    assign bus.tx_out     = tx_out_q;
    assign bus.tx_active  = tx_active_q;
    assign bus.tx_stuff   = tx_stuff_q;
    assign bus.frame_done = frame_done_q;

    // Next state and the bit to be driven on tx_out in the next cycle.
    always_comb begin
        state_nx      = state;
        shreg_nx      = shreg;
        bit_cnt_nx    = bit_cnt;
        pre_cnt_nx    = pre_cnt;
        trk_nx        = trk;
        guard_cnt_nx  = guard_cnt;
        tx_out_nx     = 1'b0;
        tx_stuff_nx   = 1'b0;
        frame_done_nx = 1'b0;
        emit_data     = 1'b0;
        trk_base      = trk;
        case (state)
            IDLE: begin
                if (bus.load_valid && load_ready_q) begin
                    state_nx   = PRE;
                    pre_cnt_nx = 3'd0;
                    tx_out_nx  = PREAMBLE[0];
                    shreg_nx   = bus.load_data;
                    bit_cnt_nx = '0;
                end
            end
            PRE: begin
                if (pre_cnt == 3'd4) begin
                    // Preamble ends in "10": two symbols of 1011 already matched.
                    state_nx  = DATA;
                    emit_data = 1'b1;
                    trk_base  = 3'd2;
                end else begin
                    pre_cnt_nx = pre_cnt + 3'd1;
                    tx_out_nx  = PREAMBLE[pre_cnt + 3'd1];
                end
            end
            DATA: begin
                if (trk == 3'd4) begin
                    state_nx    = STUFF;
                    tx_out_nx   = 1'b1;
                    tx_stuff_nx = 1'b1;
                    trk_nx      = 3'd1;
                end else if (bit_cnt == LAST_CNT) begin
                    state_nx     = GUARD;
                    guard_cnt_nx = 1'b0;
                end else begin
                    emit_data = 1'b1;
                end
            end
            STUFF: begin
                if (bit_cnt == LAST_CNT) begin
                    state_nx     = GUARD;
                    guard_cnt_nx = 1'b0;
                end else begin
                    state_nx  = DATA;
                    emit_data = 1'b1;
                    trk_base  = 3'd1;
                end
            end
            GUARD: begin
                if (!guard_cnt) begin
                    guard_cnt_nx  = 1'b1;
                    frame_done_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (emit_data) begin
            tx_out_nx  = shreg[0];
            shreg_nx   = shreg >> 1;
            bit_cnt_nx = bit_cnt + 1'b1;
            trk_nx     = next_trk(trk_base, shreg[0]);
        end
    end

    // State, datapath and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            pre_cnt      <= '0;
            trk          <= '0;
            guard_cnt    <= 1'b0;
            tx_out_q     <= 1'b0;
            tx_stuff_q   <= 1'b0;
            frame_done_q <= 1'b0;
            tx_active_q  <= 1'b0;
            load_ready_q <= 1'b0;
        end else begin
            state        <= state_nx;
            shreg        <= shreg_nx;
            bit_cnt      <= bit_cnt_nx;
            pre_cnt      <= pre_cnt_nx;
            trk          <= trk_nx;
            guard_cnt    <= guard_cnt_nx;
            tx_out_q     <= tx_out_nx;
            tx_stuff_q   <= tx_stuff_nx;
            frame_done_q <= frame_done_nx;
            tx_active_q  <= (state_nx != IDLE);
            load_ready_q <= (state_nx == IDLE);
        end
    end
endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
Serial frame transmitter for the bit-serial sync link. It is the sending end of the link whose receiver detects the sync pattern 1,0,1,1,0. It accepts a parallel payload word through a valid/ready handshake and drives one bit per clock on tx_out. Each frame is the 5-bit sync preamble, then the payload LSB first with bit stuffing, then a 2-bit zero guard. Stuffing guarantees the sync pattern never appears anywhere except at the preamble position.

Parameters:
PAYLOAD_W, 16, payload width in bits (min 4).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
load_valid  input  1  payload word offered
load_data  input  PAYLOAD_W  payload word; bit 0 is transmitted first
load_ready  output  1  block can accept a word this cycle
tx_out  output  1  registered serial line; 0 when idle
tx_active  output  1  high while a frame bit (preamble/data/stuff/guard) is on tx_out
tx_stuff  output  1  high in cycles where tx_out carries a stuffed bit
frame_done  output  1  one-cycle pulse coincident with the last guard bit

Behaviour:
- Reset (rst_n=0 at a clk edge), including mid-frame: state=IDLE; tx_out=0, tx_active=0, tx_stuff=0, frame_done=0; held payload and counters cleared. Reset overrides every other input that cycle.
- All outputs are registered. load_ready is a registered copy of state==IDLE, so it is 1 in the IDLE state and 0 while in reset.
- Handshake:
  - A word is accepted on an edge where load_valid=1 and load_ready=1; load_data is captured into a shift register.
  - load_valid while load_ready=0 is ignored; the word is not queued.
  - The first preamble bit appears on tx_out in the cycle after acceptance.
- States:
  - IDLE: tx_out=0. Acceptance moves to PRE.
  - PRE: 5 cycles emitting 1,0,1,1,0 in order. After the 5th bit, go to DATA and set tracker t=2, because the preamble ends in "10".
  - DATA: emit the next payload bit (LSB first), then update t:
    - t0: 1→1, 0→0
    - t1: 0→2, 1→1
    - t2: 1→3, 0→0
    - t3: 1→4, 0→2
  - STUFF: entered whenever t reaches 4. Emit one 1 with tx_stuff=1, then set t=1. Return to DATA if payload bits remain, otherwise go to GUARD.
  - Stuffing is unconditional after every "1011" in the data/stuff stream, regardless of the next data bit. This includes after the final payload bit.
  - GUARD: 2 cycles emitting 0; frame_done=1 on the second, then IDLE.
- Data bit counter counts PAYLOAD_W data bits and excludes stuffed bits.
- Frame length = 5 + PAYLOAD_W + (number of stuffs) + 2 cycles.
- Minimum spacing between back-to-back frames: 2 guard zeros plus 1 IDLE zero.
- tx_active=1 in PRE, DATA, STUFF and GUARD cycles.
- Invariant: no 5-bit window of the tx_out stream equals 1,0,1,1,0 except the window exactly covering a preamble. Windows spanning idle, guard and preamble boundaries are included.

Test Plan:
1. load_data=16'h0000 → tx_out = 1,0,1,1,0, then sixteen 0s, then 0,0. 23 active cycles, no tx_stuff, frame_done on cycle 23, load_ready back to 1 one cycle later.
2. load_data=16'h000D → 1,0,1,1,0 | 1,0,1,1,[1],0×12 | 0,0. tx_stuff high only on the bracketed bit; 24 active cycles.
3. load_data=16'h0003 (stuff across preamble boundary) → 1,0,1,1,0 | 1,1,[1],0×14 | 0,0; 24 cycles.
4. load_data=16'hD000 (trailing stuff) → preamble | 0×12,1,0,1,1,[1] | 0,0; frame_done on the last guard 0.
5. Robustness:
   - Pulse load_valid=1 throughout a frame → no second acceptance until load_ready=1.
   - Drive random payloads back-to-back → a reference detector on tx_out fires only on preamble boundaries.
   - Destuffing the received stream recovers every payload exactly.
6. Assert rst_n=0 for one cycle mid-DATA → next cycle tx_out=0, tx_active=0, load_ready=0; load_ready=1 on the following cycle. A new word then produces a clean preamble.
